// File: rtl/gray_conv_arbiter_pkg.sv
// Shared constants for the two-requester 8,4,-2,-1 to Gray conversion block.
// Holds the code width, requester IDs and output-stage state encodings.
package gray_conv_arbiter_pkg;

  localparam int CODE_W = 4;

  localparam logic SRC_0 = 1'b0;
  localparam logic SRC_1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : gray_conv_arbiter_pkg

// File: rtl/gray_conv_arbiter_code_84m2m1_to_gray.sv
// Combinational converter from an 8,4,-2,-1 weighted code to 4-bit Gray code.
// The six codes outside the decimal range are given values 10..15.
module code_84m2m1_to_gray
  import gray_conv_arbiter_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W-1:0] o_gray
);

  logic [CODE_W-1:0] w_value;

  // Map each weighted code onto its binary value before Gray encoding
  always_comb begin
    w_value = '0;
    case (i_code)
      4'b0000: w_value = 4'd0;
      4'b0111: w_value = 4'd1;
      4'b0110: w_value = 4'd2;
      4'b0101: w_value = 4'd3;
      4'b0100: w_value = 4'd4;
      4'b1011: w_value = 4'd5;
      4'b1010: w_value = 4'd6;
      4'b1001: w_value = 4'd7;
      4'b1000: w_value = 4'd8;
      4'b1111: w_value = 4'd9;
      4'b0001: w_value = 4'd10;
      4'b0010: w_value = 4'd11;
      4'b0011: w_value = 4'd12;
      4'b1100: w_value = 4'd13;
      4'b1101: w_value = 4'd14;
      4'b1110: w_value = 4'd15;
      default: w_value = '0;
    endcase
  end

  assign o_gray = w_value ^ (w_value >> 1);

endmodule : code_84m2m1_to_gray

// File: rtl/gray_conv_arbiter.sv
// Round-robin sharing of one 8,4,-2,-1 to Gray converter between two requesters,
// with a one-entry registered output stage tagged by source ID.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic [1:0]        req_valid,
  input  logic [CODE_W-1:0] req_code0,
  input  logic [CODE_W-1:0] req_code1,
  output logic [1:0]        req_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_gray,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  conv_count
);

  state_t            r_state;
  logic              r_last_grant;
  logic [CODE_W-1:0] r_gray;
  logic              r_src;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        w_grant;
  logic              w_can_load;
  logic              w_accept;
  logic              w_sel;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_gray;

  // On contention the requester that did not win last time is favoured
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (r_last_grant == SRC_1) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_can_load = reset_b && ((r_state == EMPTY) || out_ready);
  assign req_ready  = w_grant & {2{w_can_load}};
  assign w_accept   = |(req_valid & req_ready);
  assign w_sel      = w_grant[1] ? SRC_1 : SRC_0;
  assign w_code     = (w_sel == SRC_1) ? req_code1 : req_code0;

  code_84m2m1_to_gray u_conv (
    .i_code (w_code),
    .o_gray (w_gray)
  );

  // A drain and an accept in the same cycle keeps the stage FULL with a fresh result
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_state      <= EMPTY;
      r_last_grant <= SRC_1;
      r_gray       <= '0;
      r_src        <= SRC_0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        r_gray       <= w_gray;
        r_src        <= w_sel;
        r_last_grant <= w_sel;
        r_count      <= r_count + CNT_W'(1);
      end
      case (r_state)
        EMPTY: if (w_accept) r_state <= FULL;
        FULL:  if (out_ready && !w_accept) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid  = (r_state == FULL);
  assign out_gray   = r_gray;
  assign out_src    = r_src;
  assign conv_count = r_count;

endmodule : gray_conv_arbiter

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter; a second instance with
// a 2-bit counter shares the same stimulus to exercise counter wrap.
module tb_gray_conv_arbiter;

  logic       clock = 1'b0;
  logic       reset_b;
  logic [1:0] req_valid;
  logic [3:0] req_code0;
  logic [3:0] req_code1;
  logic       out_ready;

  logic [1:0] req_ready, req_ready_w;
  logic       out_valid, out_valid_w;
  logic [3:0] out_gray, out_gray_w;
  logic       out_src, out_src_w;
  logic [7:0] conv_count;
  logic [1:0] conv_count_w;

  int checks = 0;
  int errors = 0;

  // Expected Gray output indexed by the raw 8,4,-2,-1 input code
  logic [3:0] grayTable [16] = '{
    4'b0000, 4'b1111, 4'b1110, 4'b1010, 4'b0110, 4'b0010, 4'b0011, 4'b0001,
    4'b1100, 4'b0100, 4'b0101, 4'b0111, 4'b1011, 4'b1001, 4'b1000, 4'b1101
  };

  always #5 clock = ~clock;

  gray_conv_arbiter #(.CNT_W(8)) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .req_valid  (req_valid),
    .req_code0  (req_code0),
    .req_code1  (req_code1),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_gray   (out_gray),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  gray_conv_arbiter #(.CNT_W(2)) dutWrap (
    .clock      (clock),
    .reset_b    (reset_b),
    .req_valid  (req_valid),
    .req_code0  (req_code0),
    .req_code1  (req_code1),
    .req_ready  (req_ready_w),
    .out_valid  (out_valid_w),
    .out_gray   (out_gray_w),
    .out_src    (out_src_w),
    .out_ready  (out_ready),
    .conv_count (conv_count_w)
  );

  task automatic applyStimulus(input logic rb, input logic [1:0] v,
                               input logic [3:0] c0, input logic [3:0] c1,
                               input logic ordy);
    reset_b   = rb;
    req_valid = v;
    req_code0 = c0;
    req_code1 = c1;
    out_ready = ordy;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held two cycles with both requesters valid
    applyStimulus(1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1);
    checkOutput("reset_ready_comb", 32'(req_ready), 32'h0);
    stepClock();
    stepClock();
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_gray", 32'(out_gray), 32'h0);
    checkOutput("reset_src", 32'(out_src), 32'h0);
    checkOutput("reset_count", 32'(conv_count), 32'h0);
    checkOutput("reset_ready", 32'(req_ready), 32'h0);

    // Exhaustive conversion through requester 0
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, 2'b01, 4'(c), 4'b0000, 1'b1);
      checkOutput("conv_ready", 32'(req_ready), 32'h1);
      stepClock();
      checkOutput($sformatf("conv_valid_%0d", c), 32'(out_valid), 32'h1);
      checkOutput($sformatf("conv_gray_%0d", c), 32'(out_gray), 32'(grayTable[c]));
      checkOutput($sformatf("conv_src_%0d", c), 32'(out_src), 32'h0);
    end
    checkOutput("conv_count16", 32'(conv_count), 32'd16);
    applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b1);
    stepClock();
    checkOutput("drain_valid", 32'(out_valid), 32'h0);
    checkOutput("drain_gray_held", 32'(out_gray), 32'b1101);

    // Contention from reset: 0,1,0,1,0 and 2-bit counter wraps 1,2,3,0,1
    applyStimulus(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
    stepClock();
    applyStimulus(1'b1, 2'b11, 4'b0100, 4'b1111, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      stepClock();
      checkOutput($sformatf("cont_src_%0d", k), 32'(out_src), 32'((k - 1) % 2));
      checkOutput($sformatf("cont_gray_%0d", k), 32'(out_gray),
                  (k % 2 == 1) ? 32'b0110 : 32'b1101);
      checkOutput($sformatf("cont_count_%0d", k), 32'(conv_count), 32'(k));
      checkOutput($sformatf("wrap_count_%0d", k), 32'(conv_count_w), 32'(k % 4));
    end

    // Backpressure: hold result while consumer stalls
    applyStimulus(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
    stepClock();
    applyStimulus(1'b1, 2'b01, 4'b0111, 4'b0000, 1'b1);
    stepClock();
    checkOutput("bp_first_gray", 32'(out_gray), 32'b0001);
    checkOutput("bp_first_count", 32'(conv_count), 32'd1);
    applyStimulus(1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_ready", 32'(req_ready), 32'h0);
      stepClock();
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_gray", 32'(out_gray), 32'b0001);
      checkOutput("bp_src", 32'(out_src), 32'h0);
      checkOutput("bp_count", 32'(conv_count), 32'd1);
    end
    applyStimulus(1'b1, 2'b01, 4'b1111, 4'b0000, 1'b1);
    checkOutput("bp_release_ready", 32'(req_ready), 32'h1);
    stepClock();
    checkOutput("bp_reload_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_reload_gray", 32'(out_gray), 32'b1101);
    checkOutput("bp_reload_count", 32'(conv_count), 32'd2);

    // Reset mid-operation while FULL and stalled; last grant was requester 0
    applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0);
    stepClock();
    checkOutput("mid_full", 32'(out_valid), 32'h1);
    applyStimulus(1'b0, 2'b11, 4'b0100, 4'b1111, 1'b0);
    checkOutput("mid_reset_ready", 32'(req_ready), 32'h0);
    stepClock();
    checkOutput("mid_reset_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_reset_count", 32'(conv_count), 32'h0);
    applyStimulus(1'b1, 2'b11, 4'b0100, 4'b1111, 1'b1);
    checkOutput("mid_first_grant", 32'(req_ready), 32'h1);
    stepClock();
    checkOutput("mid_first_src", 32'(out_src), 32'h0);
    checkOutput("mid_first_gray", 32'(out_gray), 32'b0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gray_conv_arbiter
